// File: rtl/loom_axil_host_master.sv
// Single-outstanding AXI-Lite initiator: turns a valid/ready request/response port into
// AW/W/B or AR/R transactions, with a response watchdog and draining of late responses.
module loom_axil_host_master #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_wstrb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic [1:0]        rsp_resp_o,
  output logic              rsp_timeout_o,
  output logic              busy_o,
  output logic [2:0]        dbg_state_o,
  output logic [ADDR_W-1:0] m_axil_awaddr,
  output logic              m_axil_awvalid,
  input  logic              m_axil_awready,
  output logic [31:0]       m_axil_wdata,
  output logic [3:0]        m_axil_wstrb,
  output logic              m_axil_wvalid,
  input  logic              m_axil_wready,
  input  logic [1:0]        m_axil_bresp,
  input  logic              m_axil_bvalid,
  output logic              m_axil_bready,
  output logic [ADDR_W-1:0] m_axil_araddr,
  output logic              m_axil_arvalid,
  input  logic              m_axil_arready,
  input  logic [31:0]       m_axil_rdata,
  input  logic [1:0]        m_axil_rresp,
  input  logic              m_axil_rvalid,
  output logic              m_axil_rready
);

  // Every channel transfers on the clock edge where valid && ready are both 1; a valid,
  // once raised, stays up with stable payload until that edge.
  typedef enum logic [2:0] {
    StIdle, StWrite, StWrResp, StRead, StRdResp, StRsp, StDrain
  } state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              write_q, write_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic              bready_q, bready_d, rready_q, rready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              aw_done, w_done;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    aw_done   = !awvalid_q || m_axil_awready;
    w_done    = !wvalid_q || m_axil_wready;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_wstrb_i;
          write_d = req_write_i;
          if (req_write_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrite;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRead;
          end
        end
      end
      StWrite: begin
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          cnt_d    = '0;
          state_d  = StWrResp;
        end
      end
      StRead: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = StRdResp;
        end
      end
      StWrResp, StRdResp: begin
        // A response on the expiry cycle takes priority over the watchdog.
        if (state_q == StWrResp && m_axil_bvalid) begin
          resp_d    = m_axil_bresp;
          rdata_d   = '0;
          timeout_d = 1'b0;
          bready_d  = 1'b0;
          state_d   = StRsp;
        end else if (state_q == StRdResp && m_axil_rvalid) begin
          resp_d    = m_axil_rresp;
          rdata_d   = m_axil_rdata;
          timeout_d = 1'b0;
          rready_d  = 1'b0;
          state_d   = StRsp;
        end else if (WD_EN && cnt_q == CNT_LAST) begin
          resp_d    = 2'b10;
          rdata_d   = '0;
          timeout_d = 1'b1;
          bready_d  = 1'b0;
          rready_d  = 1'b0;
          state_d   = StRsp;
        end else if (WD_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready_i) begin
          if (timeout_q) begin
            // The slave still owes a response; accept and discard it before going idle.
            bready_d = write_q;
            rready_d = !write_q;
            state_d  = StDrain;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrain: begin
        if ((write_q && m_axil_bvalid) || (!write_q && m_axil_rvalid)) begin
          bready_d = 1'b0;
          rready_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready_o    = (state_q == StIdle);
  assign rsp_valid_o    = (state_q == StRsp);
  assign rsp_rdata_o    = rdata_q;
  assign rsp_resp_o     = resp_q;
  assign rsp_timeout_o  = timeout_q;
  assign busy_o         = (state_q != StIdle);
  assign dbg_state_o    = state_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule
